io_bus_router: RTL
==================

// Module: io_bus_router
// PURPOSE
//  Data-side bus router for Raisin64. Sits downstream of the physical memory-map
//  decoder and consumes its io/led/sw/vga selects to steer one CPU load/store to RAM,
//  the VGA window or the local LED/switch registers.
//  Returns read data and a one-cycle ack (plus err) to the CPU memory stage.
//  One transaction is outstanding at a time.
// PARAMETERS
//  LED_W           16   width of the LED output register
//  SW_W            16   width of the switch input
//  VGA_AW          18   VGA window address width (byte address bits [17:0])
//  TIMEOUT_CYCLES  255  downstream wait limit; used only with BUS_TIMEOUT_EN
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous, active-high reset
//  cpu_req    in   1       1-cycle request pulse; sampled only in IDLE
//  cpu_we     in   1       1 = store, 0 = load
//  cpu_addr   in   64      physical address
//  cpu_wdata  in   64      store data
//  sel_io     in   1       decoder: address in IO half
//  sel_led    in   1       decoder: LED page
//  sel_sw     in   1       decoder: switch page
//  sel_vga    in   1       decoder: VGA window
//  cpu_busy   out  1       high whenever FSM != IDLE
//  cpu_ack    out  1       1-cycle completion pulse
//  cpu_err    out  1       valid with cpu_ack: unmapped IO or timeout
//  cpu_rdata  out  64      load data, valid with cpu_ack
//  ram_req    out  1       held high until ram_ack
//  ram_we     out  1       store flag
//  ram_addr   out  64      captured cpu_addr
//  ram_wdata  out  64      captured cpu_wdata
//  ram_rdata  in   64      RAM load data, valid with ram_ack
//  ram_ack    in   1       RAM completion
//  vga_req    out  1       held high until vga_ack
//  vga_we     out  1       store flag
//  vga_addr   out  VGA_AW  cpu_addr[VGA_AW-1:0]
//  vga_wdata  out  64      captured cpu_wdata
//  vga_rdata  in   64      VGA load data, valid with vga_ack
//  vga_ack    in   1       VGA completion
//  led        out  LED_W   LED register
//  sw         in   SW_W    raw switches, asynchronous
// BEHAVIOUR
//  - Clocking: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset: every output is 0, including led; FSM = IDLE; timeout counter = 0.
//  - Reset mid-transaction: the in-flight request is dropped and no ack is issued.
//    Any ram_ack or vga_ack arriving after reset is ignored.
//  - Switch input: sw passes through a 2-flop synchroniser (reset 0) before any read.
//  - FSM states: IDLE, RAM, VGA, DONE.
//  - IDLE: on cpu_req, capture we, addr and wdata, then branch:
//      !sel_io            -> RAM
//      sel_vga            -> VGA
//      sel_led | sel_sw   -> DONE (local access)
//      sel_io, no page    -> DONE with err=1, rdata=0
//  - Select priority: vga > led > sw.
//  - Local access: an LED store writes led <= wdata[LED_W-1:0]. A load returns the
//    zero-extended led or synchronised sw. A switch store is discarded and
//    acknowledged with err=0.
//  - RAM/VGA states: xxx_req is high from the cycle after capture. On xxx_ack (which
//    may arrive the same cycle req first rises), drop req, register rdata (0 for a
//    store), go to DONE.
//  - DONE: cpu_ack=1 for exactly one cycle, cpu_err as set, then IDLE.
//    cpu_rdata holds its value until the next ack.
//  - Latency: local/unmapped ack at cycle+1 after cpu_req; RAM/VGA ack one cycle after
//    the downstream ack.
//  - cpu_req while busy (including the DONE cycle) is ignored. The next accept is
//    earliest in the cycle after ack.
//  - A downstream ack while that channel is not requesting is ignored.
// CONFIGURATION
//  - BUS_TIMEOUT_EN defined: a counter runs in RAM/VGA. When it reaches
//    TIMEOUT_CYCLES with no ack, drop req, go to DONE with err=1, rdata=0.
//    The counter clears on every capture.
//  - BUS_TIMEOUT_EN undefined: RAM/VGA wait indefinitely, no counter is built, and
//    cpu_err is raised only for unmapped IO.
// TESTING
//  1. Store to an LED-page address, wdata=0x...00A5A5 -> ack at cycle+1, err=0,
//     led=0xA5A5; a following load returns 0x000000000000A5A5.
//  2. sw=0x1234 held 3 cycles, then load from the switch page -> rdata=0x1234,
//     ack at cycle+1.
//  3. RAM load addr=0x1000; model acks 4 cycles after ram_req with 0xDEADBEEF ->
//     ram_req high 4 cycles, cpu_ack 1 cycle later, rdata=0xDEADBEEF, err=0.
//  4. Load with sel_io=1 and no page select -> ack+err at cycle+1, rdata=0,
//     led unchanged.
//  5. cpu_req re-pulsed while a VGA access waits -> ignored, exactly one vga_req
//     sequence and one ack. Assert rst mid-wait -> vga_req=0, no ack, a late
//     vga_ack is ignored.
//  6. BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, RAM never acks -> ram_req drops after
//     8 cycles, ack+err, rdata=0.
//     Without the macro -> still busy after 1000 cycles.

Source files
------------

// File: rtl/io_bus_router_if.sv
// CPU, RAM and VGA bus signals of io_bus_router grouped into one bundle.
// slave is the router's view; master is the CPU/decoder/downstream side.
interface io_bus_router_if #(
  parameter int unsigned VGA_AW = 18
);
  logic              cpu_req;
  logic              cpu_we;
  logic [63:0]       cpu_addr;
  logic [63:0]       cpu_wdata;
  logic              sel_io;
  logic              sel_led;
  logic              sel_sw;
  logic              sel_vga;
  logic              cpu_busy;
  logic              cpu_ack;
  logic              cpu_err;
  logic [63:0]       cpu_rdata;
  logic              ram_req;
  logic              ram_we;
  logic [63:0]       ram_addr;
  logic [63:0]       ram_wdata;
  logic [63:0]       ram_rdata;
  logic              ram_ack;
  logic              vga_req;
  logic              vga_we;
  logic [VGA_AW-1:0] vga_addr;
  logic [63:0]       vga_wdata;
  logic [63:0]       vga_rdata;
  logic              vga_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  sel_io, sel_led, sel_sw, sel_vga,
    output cpu_busy, cpu_ack, cpu_err, cpu_rdata,
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack,
    output vga_req, vga_we, vga_addr, vga_wdata,
    input  vga_rdata, vga_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output sel_io, sel_led, sel_sw, sel_vga,
    input  cpu_busy, cpu_ack, cpu_err, cpu_rdata,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ack,
    input  vga_req, vga_we, vga_addr, vga_wdata,
    output vga_rdata, vga_ack
  );
endinterface

// File: rtl/io_bus_router.sv
// Raisin64 data-side router: steers one CPU load/store to RAM, VGA or local LED/SW regs.
// Optional macro BUS_TIMEOUT_EN adds a downstream wait limit of TIMEOUT_CYCLES.
module io_bus_router #(
  parameter int unsigned LED_W          = 16,
  parameter int unsigned SW_W           = 16,
  parameter int unsigned VGA_AW         = 18,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  io_bus_router_if.slave   bus,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw
);

  typedef enum logic [1:0] {IDLE, RAM, VGA, DONE} state_e;

  state_e           state_q;
  logic             we_q;
  logic [63:0]      addr_q;
  logic [63:0]      wdata_q;
  logic [63:0]      rdata_q;
  logic             busy_q;
  logic             ack_q;
  logic             err_q;
  logic             ram_req_q;
  logic             vga_req_q;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_meta_q;
  logic [SW_W-1:0]  sw_sync_q;

  logic             ds_ack;
  logic [63:0]      ds_rdata;
  logic [63:0]      local_rdata;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // An ack on the channel not currently in use is never looked at.
  always_comb begin
    ds_ack      = 1'b0;
    ds_rdata    = bus.ram_rdata;
    local_rdata = '0;
    if (state_q == RAM) begin
      ds_ack = bus.ram_ack;
    end else if (state_q == VGA) begin
      ds_ack   = bus.vga_ack;
      ds_rdata = bus.vga_rdata;
    end
    if (!bus.cpu_we) begin
      local_rdata = bus.sel_led ? 64'(led_q) : 64'(sw_sync_q);
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q;

  assign timeout = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && bus.cpu_req) begin
      cnt_q <= '0;
    end else if ((state_q == RAM || state_q == VGA) && !ds_ack && !timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ram_req_q <= 1'b0;
      vga_req_q <= 1'b0;
      led_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            we_q    <= bus.cpu_we;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            busy_q  <= 1'b1;
            if (!bus.sel_io) begin
              state_q   <= RAM;
              ram_req_q <= 1'b1;
            end else if (bus.sel_vga) begin
              state_q   <= VGA;
              vga_req_q <= 1'b1;
            end else begin
              // Local page or unmapped IO completes without a downstream wait.
              state_q <= DONE;
              ack_q   <= 1'b1;
              err_q   <= !(bus.sel_led || bus.sel_sw);
              rdata_q <= (bus.sel_led || bus.sel_sw) ? local_rdata : '0;
              if (bus.sel_led && bus.cpu_we) begin
                led_q <= bus.cpu_wdata[LED_W-1:0];
              end
            end
          end
        end
        RAM, VGA: begin
          if (ds_ack || timeout) begin
            state_q   <= DONE;
            ram_req_q <= 1'b0;
            vga_req_q <= 1'b0;
            ack_q     <= 1'b1;
            err_q     <= !ds_ack;
            rdata_q   <= (ds_ack && !we_q) ? ds_rdata : '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_busy  = busy_q;
  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.ram_req   = ram_req_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.vga_req   = vga_req_q;
  assign bus.vga_we    = we_q;
  assign bus.vga_addr  = addr_q[VGA_AW-1:0];
  assign bus.vga_wdata = wdata_q;
  assign led           = led_q;

endmodule
